fwd_scoreboard: RTL and testbench

//  Parametrised bypass/interlock unit for the in-order GenshinCPU pipeline; sits beside ID/EXE.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_prio_sel.sv | 33 +++
 rtl/fwd_scoreboard.sv | 105 ++++++++++
 tb/tb_fwd_scoreboard.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared constants, types and helpers for the bypass/interlock unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    localparam int         FWD_RF     = 0;      // fwd_sel code: operand comes from the register file
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         LAT_W_DFLT = 3;

    typedef logic [LAT_W_DFLT-1:0] pend_cnt_t;

    function automatic int fsel_w(input int num_fwd);
        return $clog2(num_fwd + 1);
    endfunction

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_prio_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_prio_sel
// Description : Priority match of one source operand against the forwarding stages.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_prio_sel
    import fwd_pkg::*;
#(
    parameter int NUM_FWD = 2,
    parameter int FSEL_W  = fsel_w(NUM_FWD)
) (
    input  logic                 src_used,
    input  logic [4:0]           src_addr,
    input  logic [NUM_FWD-1:0]   fwd_wr,
    input  logic [NUM_FWD*5-1:0] fwd_dst,
    output logic [FSEL_W-1:0]    sel
);

    // Scan oldest to youngest so the youngest matching stage is the last writer.
    always_comb begin
        sel = FSEL_W'(FWD_RF);
        if (src_used && (src_addr != REG_ZERO)) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_wr[k] && (fwd_dst[k*5 +: 5] == src_addr)) begin
                    sel = FSEL_W'(k + 1);
                end
            end
        end
    end

endmodule : fwd_prio_sel
`default_nettype wire

// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Per-register countdown scoreboard raising RAW/WAW issue stalls
//               and selecting bypass sources for each operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_FWD    = 2,
    parameter int LAT_W      = LAT_W_DFLT,
    parameter int STALLCNT_W = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                pipe_hold,
    input  logic                                issue_valid,
    input  logic                                issue_wr,
    input  logic [4:0]                          issue_dst,
    input  logic [LAT_W-1:0]                    issue_lat,
    input  logic [NUM_SRC-1:0]                  src_used,
    input  logic [NUM_SRC*5-1:0]                src_addr,
    input  logic [NUM_FWD-1:0]                  fwd_wr,
    input  logic [NUM_FWD*5-1:0]                fwd_dst,
    output logic [NUM_SRC*fsel_w(NUM_FWD)-1:0]  fwd_sel,
    output logic                                id_stall,
    output logic                                issue_accept,
    output logic [STALLCNT_W-1:0]               stall_cycles
);

    localparam int FSEL_W = fsel_w(NUM_FWD);

    // Entry 0 is held at zero so r0 lookups need no special-casing.
    logic [LAT_W-1:0]      r_pend_cnt [0:31];
    logic [STALLCNT_W-1:0] r_stall_cycles;
    logic                  w_raw;
    logic                  w_waw;
    logic [4:0]            w_src;

    always_comb begin
        w_raw = 1'b0;
        w_src = REG_ZERO;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src = src_addr[i*5 +: 5];
            if (src_used[i] && (w_src != REG_ZERO) && (r_pend_cnt[w_src] != '0)) begin
                w_raw = 1'b1;
            end
        end
        w_raw = w_raw & issue_valid;
    end

    // A short producer must not retire ahead of an older, longer one to the same register.
    assign w_waw = issue_valid && issue_wr && (issue_dst != REG_ZERO)
                   && (r_pend_cnt[issue_dst] > issue_lat);

    assign id_stall     = (w_raw | w_waw) & ~flush;
    assign issue_accept = issue_valid & ~id_stall & ~pipe_hold & ~flush;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < 32; i++) begin
                r_pend_cnt[i] <= '0;
            end
        end else if (!pipe_hold) begin
            for (int i = 0; i < 32; i++) begin
                if (i == 0) begin
                    r_pend_cnt[i] <= '0;
                end else if (issue_accept && issue_wr && (issue_dst == 5'(i))) begin
                    r_pend_cnt[i] <= issue_lat;
                end else if (r_pend_cnt[i] != '0) begin
                    r_pend_cnt[i] <= r_pend_cnt[i] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (id_stall && !pipe_hold && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALLCNT_W'(1);
        end
    end

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_prio_sel #(
                .NUM_FWD (NUM_FWD),
                .FSEL_W  (FSEL_W)
            ) u_prio_sel (
                .src_used (src_used[g]),
                .src_addr (src_addr[g*5 +: 5]),
                .fwd_wr   (fwd_wr),
                .fwd_dst  (fwd_dst),
                .sel      (fwd_sel[g*FSEL_W +: FSEL_W])
            );
        end
    endgenerate

endmodule : fwd_scoreboard
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Directed and randomized checks of fwd_scoreboard against a
//               register-level countdown model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        pipe_hold;
    logic        issue_valid;
    logic        issue_wr;
    logic [4:0]  issue_dst;
    logic [2:0]  issue_lat;
    logic [1:0]  src_used;
    logic [9:0]  src_addr;
    logic [1:0]  fwd_wr;
    logic [9:0]  fwd_dst;
    logic [3:0]  fwd_sel;
    logic        id_stall;
    logic        issue_accept;
    logic [31:0] stall_cycles;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_pend [32];
    logic [31:0] m_cnt;
    bit          e_stall;
    bit          e_acc;

    fwd_scoreboard #(
        .NUM_SRC    (2),
        .NUM_FWD    (2),
        .LAT_W      (3),
        .STALLCNT_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .pipe_hold    (pipe_hold),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_dst    (issue_dst),
        .issue_lat    (issue_lat),
        .src_used     (src_used),
        .src_addr     (src_addr),
        .fwd_wr       (fwd_wr),
        .fwd_dst      (fwd_dst),
        .fwd_sel      (fwd_sel),
        .id_stall     (id_stall),
        .issue_accept (issue_accept),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input bit wr, input int dst, input int lat,
                          input int used, input int a0, input int a1,
                          input int fw, input int d0, input int d1,
                          input bit hold, input bit fl);
        issue_valid = v;
        issue_wr    = wr;
        issue_dst   = 5'(dst);
        issue_lat   = 3'(lat);
        src_used    = 2'(used);
        src_addr    = {5'(a1), 5'(a0)};
        fwd_wr      = 2'(fw);
        fwd_dst     = {5'(d1), 5'(d0)};
        pipe_hold   = hold;
        flush       = fl;
    endtask

    // Model outputs derived from the register countdown table and the present inputs.
    task automatic sample();
        bit         raw;
        bit         waw;
        logic [4:0] a;
        int         e;
        @(negedge clk);
        raw = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = src_addr[i*5 +: 5];
            if (issue_valid && src_used[i] && a != 0 && m_pend[a] != 0) raw = 1'b1;
        end
        waw = issue_valid && issue_wr && issue_dst != 0 && m_pend[issue_dst] > int'(issue_lat);
        e_stall = (raw || waw) && !flush;
        e_acc   = issue_valid && !e_stall && !pipe_hold && !flush;
        chk("id_stall", 32'(id_stall), 32'(e_stall));
        chk("issue_accept", 32'(issue_accept), 32'(e_acc));
        chk("stall_cycles", stall_cycles, m_cnt);
        for (int i = 0; i < 2; i++) begin
            a = src_addr[i*5 +: 5];
            e = 0;
            if (src_used[i] && a != 0) begin
                for (int k = 0; k < 2; k++) begin
                    if (e == 0 && fwd_wr[k] && fwd_dst[k*5 +: 5] == a) e = k + 1;
                end
            end
            chk($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*2 +: 2]), 32'(e));
        end
    endtask

    task automatic advance();
        if (rst) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_cnt = '0;
        end else begin
            if (e_stall && !pipe_hold && m_cnt != '1) m_cnt = m_cnt + 1;
            if (flush) begin
                for (int r = 0; r < 32; r++) m_pend[r] = 0;
            end else if (!pipe_hold) begin
                for (int r = 1; r < 32; r++) if (m_pend[r] > 0) m_pend[r] = m_pend[r] - 1;
                if (e_acc && issue_wr && issue_dst != 0) m_pend[issue_dst] = int'(issue_lat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample();
        advance();
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_cnt = '0;
        rst   = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_stall_cycles", stall_cycles, 32'd0);

        // ALU producer then an immediate reader bypassed from stage 0
        set_in(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); chk("alu_accept", 32'(issue_accept), 32'd1); advance();
        set_in(1, 1, 10, 0, 1, 3, 0, 1, 3, 0, 0, 0);
        sample(); chk("alu_reader_stall", 32'(id_stall), 32'd0);
        chk("alu_reader_sel", 32'(fwd_sel[1:0]), 32'd1); advance();

        // Load-use: two stall cycles then forward from stage 0
        do_reset();
        set_in(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); chk("load_accept", 32'(issue_accept), 32'd1); advance();
        set_in(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        sample(); chk("load_use_stall1", 32'(id_stall), 32'd1); advance();
        sample(); chk("load_use_stall2", 32'(id_stall), 32'd1); advance();
        set_in(1, 0, 0, 0, 1, 5, 0, 1, 5, 0, 0, 0);
        sample(); chk("load_use_release", 32'(id_stall), 32'd0);
        chk("load_use_sel", 32'(fwd_sel[1:0]), 32'd1);
        chk("load_use_count", stall_cycles, 32'd2); advance();

        // Youngest stage wins
        set_in(0, 0, 0, 0, 3, 7, 7, 3, 7, 7, 0, 0);
        sample(); chk("youngest_sel0", 32'(fwd_sel[1:0]), 32'd1);
        chk("youngest_sel1", 32'(fwd_sel[3:2]), 32'd1); advance();
        set_in(0, 0, 0, 0, 1, 7, 0, 2, 7, 7, 0, 0);
        sample(); chk("oldest_only_sel", 32'(fwd_sel[1:0]), 32'd2); advance();

        // WAW: ALU write behind a 4-cycle multiply
        set_in(1, 1, 8, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); advance();
        set_in(1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            sample(); chk($sformatf("waw_stall%0d", c), 32'(id_stall), 32'd1); advance();
        end
        sample(); chk("waw_release", 32'(issue_accept), 32'd1); advance();

        // pipe_hold freezes the countdown
        set_in(1, 1, 9, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); advance();
        set_in(1, 0, 0, 0, 2, 0, 9, 0, 0, 0, 1, 0);
        for (int c = 0; c < 2; c++) begin
            sample(); chk($sformatf("hold_stall%0d", c), 32'(id_stall), 32'd1);
            chk($sformatf("hold_accept%0d", c), 32'(issue_accept), 32'd0); advance();
        end
        pipe_hold = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample(); chk($sformatf("post_hold_stall%0d", c), 32'(id_stall), 32'd1); advance();
        end
        sample(); chk("post_hold_release", 32'(id_stall), 32'd0); advance();

        // Flush clears pending entries and beats a same-cycle issue
        set_in(1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); advance();
        set_in(1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 1);
        sample(); chk("flush_stall", 32'(id_stall), 32'd0);
        chk("flush_accept", 32'(issue_accept), 32'd0); advance();
        flush = 1'b0;
        sample(); chk("after_flush_stall", 32'(id_stall), 32'd0);
        chk("after_flush_accept", 32'(issue_accept), 32'd1); advance();

        // r0 never pending or forwarded
        set_in(1, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        sample(); advance();
        set_in(1, 1, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
        sample(); chk("r0_stall", 32'(id_stall), 32'd0);
        chk("r0_sel", 32'(fwd_sel[1:0]), 32'd0); advance();

        // Randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 255) == 0);
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 15) == 0);
            sample();
            advance();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_fwd_scoreboard
`default_nettype wire
